// File: rtl/aircon_off_timer_pkg.sv
// Shared types and defaults for the airconditioner power-off timer.
package aircon_off_timer_pkg;

  localparam int unsigned VAL_W_DEF          = 5;
  localparam int unsigned TICKS_PER_UNIT_DEF = 60;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_ON     = 3'd1,
    ST_RUN    = 3'd2,
    ST_EXPIRE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

endpackage

// File: rtl/aircon_off_timer_unit_tick_gen.sv
// Prescaler for the off timer: pulses tick_c_o on the last clk cycle of each timer unit.
module aircon_off_timer_unit_tick_gen #(
  parameter int unsigned TICKS = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c_o = enable_i && (cnt_q == TERM);

  // clear wins over counting so a restart always begins a full unit
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_c_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aircon_off_timer.sv
// Power-gating stage: counts the timer setting down in units and cuts power on expiry,
// holding it off until the user releases and re-asserts the power request.
module aircon_off_timer
  import aircon_off_timer_pkg::*;
#(
  parameter int unsigned VAL_W          = VAL_W_DEF,
  parameter int unsigned TICKS_PER_UNIT = TICKS_PER_UNIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_in_i,
  input  logic [VAL_W-1:0] timer_val_i,
  input  logic             timer_load_i,
  input  logic             cancel_i,
  output logic             pwr_out_o,
  output logic [VAL_W-1:0] remaining_o,
  output logic             running_o,
  output logic             expired_o
);

  state_e           state_q, state_d;
  logic [VAL_W-1:0] remaining_q, remaining_d;
  logic             pwr_out_q, running_q, expired_q;
  logic             restart_c;
  logic             tick_c;
  logic             load_nz_c;
  logic             presc_clear_c;

  assign load_nz_c     = timer_load_i && (timer_val_i != '0);
  assign presc_clear_c = (state_d != ST_RUN) || restart_c;

  aircon_off_timer_unit_tick_gen #(
    .TICKS (TICKS_PER_UNIT)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (presc_clear_c),
    .enable_i (state_q == ST_RUN),
    .tick_c_o (tick_c)
  );

  // Next state and remaining count; RUN priority: power drop > cancel > load > tick
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    restart_c   = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (pwr_in_i) state_d = ST_ON;
      end
      ST_ON: begin
        if (!pwr_in_i) begin
          state_d = ST_OFF;
        end else if (load_nz_c) begin
          state_d     = ST_RUN;
          remaining_d = timer_val_i;
          restart_c   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!pwr_in_i) begin
          state_d     = ST_OFF;
          remaining_d = '0;
        end else if (cancel_i || (timer_load_i && !load_nz_c)) begin
          state_d     = ST_ON;
          remaining_d = '0;
        end else if (load_nz_c) begin
          remaining_d = timer_val_i;
          restart_c   = 1'b1;
        end else if (tick_c) begin
          if (remaining_q <= VAL_W'(1)) begin
            state_d     = ST_EXPIRE;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - VAL_W'(1);
          end
        end
      end
      ST_EXPIRE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!pwr_in_i) state_d = ST_OFF;
      end
      default: begin
        state_d     = ST_OFF;
        remaining_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      remaining_q <= '0;
      pwr_out_q   <= 1'b0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pwr_out_q   <= (state_d == ST_ON) || (state_d == ST_RUN);
      running_q   <= (state_d == ST_RUN);
      expired_q   <= (state_d == ST_EXPIRE);
    end
  end

  assign pwr_out_o   = pwr_out_q;
  assign remaining_o = remaining_q;
  assign running_o   = running_q;
  assign expired_o   = expired_q;

endmodule

// File: tb/tb_aircon_off_timer.sv
// Bench for aircon_off_timer: directed scenarios then random traffic against a cycle-count model.
module tb_aircon_off_timer;

  localparam int unsigned VAL_W = 5;
  localparam int unsigned TPU   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwr_in;
  logic [VAL_W-1:0] timer_val;
  logic             timer_load;
  logic             cancel;
  logic             pwr_out;
  logic [VAL_W-1:0] remaining;
  logic             running;
  logic             expired;

  int checks = 0;
  int errors = 0;

  // Model: power flag, post-expiry hold, expiry pulse and clk cycles left in the countdown
  bit m_on   = 1'b0;
  bit m_hold = 1'b0;
  bit m_exp  = 1'b0;
  int m_left = 0;

  always #5 clk = ~clk;

  aircon_off_timer #(
    .VAL_W          (VAL_W),
    .TICKS_PER_UNIT (TPU)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pwr_in_i     (pwr_in),
    .timer_val_i  (timer_val),
    .timer_load_i (timer_load),
    .cancel_i     (cancel),
    .pwr_out_o    (pwr_out),
    .remaining_o  (remaining),
    .running_o    (running),
    .expired_o    (expired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit p, input bit l, input bit c, input int v);
    rst        = r;
    pwr_in     = p;
    timer_load = l;
    cancel     = c;
    timer_val  = VAL_W'(v);
  endtask

  task automatic model_step();
    int val;
    val = int'(timer_val);
    if (rst) begin
      m_on = 0; m_hold = 0; m_exp = 0; m_left = 0;
    end else if (m_exp) begin
      m_exp  = 0;
      m_hold = 1;
    end else if (m_hold) begin
      if (!pwr_in) m_hold = 0;
    end else if (!m_on) begin
      if (pwr_in) m_on = 1;
    end else if (!pwr_in) begin
      m_on   = 0;
      m_left = 0;
    end else if (m_left > 0) begin
      if (cancel) m_left = 0;
      else if (timer_load) m_left = val * int'(TPU);
      else begin
        m_left--;
        if (m_left == 0) begin
          m_on  = 0;
          m_exp = 1;
        end
      end
    end else if (timer_load && val != 0) begin
      m_left = val * int'(TPU);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("pwr_out", 32'(pwr_out), 32'(m_on));
    check("running", 32'(running), 32'(m_left > 0));
    check("remaining", 32'(remaining), 32'((m_left + int'(TPU) - 1) / int'(TPU)));
    check("expired", 32'(expired), 32'(m_exp));
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    check("rst_pwr", 32'(pwr_out), 32'd0);

    // power on
    drive(0, 1, 0, 0, 0);
    step();
    check("t1_pwr", 32'(pwr_out), 32'd1);

    // full 3-unit countdown, expiry and hold
    drive(0, 1, 1, 0, 3);
    step();
    check("t2_rem3", 32'(remaining), 32'd3);
    drive(0, 1, 0, 0, 0);
    repeat (3) step();
    step();
    check("t2_rem2", 32'(remaining), 32'd2);
    repeat (7) step();
    check("t2_noexp", 32'(expired), 32'd0);
    step();
    check("t2_exp", 32'(expired), 32'd1);
    check("t2_exp_pwr", 32'(pwr_out), 32'd0);
    step();
    check("t2_exp_low", 32'(expired), 32'd0);
    repeat (3) step();
    check("t2_hold", 32'(pwr_out), 32'd0);
    drive(0, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 0, 0);
    step();
    check("t2_repower", 32'(pwr_out), 32'd1);

    // cancel mid-run
    drive(0, 1, 1, 0, 3);
    step();
    drive(0, 1, 0, 0, 0);
    repeat (4) step();
    drive(0, 1, 0, 1, 0);
    step();
    check("t3_run", 32'(running), 32'd0);
    check("t3_pwr", 32'(pwr_out), 32'd1);

    // zero load ignored, reload at remaining=1
    drive(0, 1, 1, 0, 0);
    step();
    check("t4_zero", 32'(running), 32'd0);
    drive(0, 1, 1, 0, 3);
    step();
    drive(0, 1, 0, 0, 0);
    repeat (8) step();
    check("t4_rem1", 32'(remaining), 32'd1);
    drive(0, 1, 1, 0, 5);
    step();
    check("t4_rem5", 32'(remaining), 32'd5);
    drive(0, 1, 0, 0, 0);
    repeat (19) step();
    check("t4_pre", 32'(expired), 32'd0);
    step();
    check("t4_exp", 32'(expired), 32'd1);
    drive(0, 0, 0, 0, 0);
    repeat (2) step();
    drive(0, 1, 0, 0, 0);
    step();

    // power drop beats cancel and load; cancel beats load
    drive(0, 1, 1, 0, 4);
    step();
    drive(0, 1, 0, 0, 0);
    repeat (2) step();
    drive(0, 0, 1, 1, 4);
    step();
    check("t5_off", 32'(pwr_out), 32'd0);
    drive(0, 1, 0, 0, 0);
    step();
    drive(0, 1, 1, 0, 4);
    step();
    drive(0, 1, 0, 0, 0);
    step();
    drive(0, 1, 1, 1, 4);
    step();
    check("t5_cancel", 32'(remaining), 32'd0);
    check("t5_on", 32'(pwr_out), 32'd1);

    // reset mid-run
    drive(0, 1, 1, 0, 3);
    step();
    drive(0, 1, 0, 0, 0);
    step();
    drive(1, 1, 1, 0, 3);
    step();
    check("t6_pwr", 32'(pwr_out), 32'd0);
    check("t6_run", 32'(running), 32'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, p, l, c;
      int v;
      r = ($urandom_range(0, 199) == 0);
      p = ($urandom_range(0, 29) == 0) ? ~pwr_in : pwr_in;
      l = ($urandom_range(0, 11) == 0);
      c = ($urandom_range(0, 23) == 0);
      v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      drive(r, p, l, c, v);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
